cache_nway: RTL and testbench

Parametrised N-way set-associative cache array with tree pseudo-LRU replacement, a latched victim way for write-back/fill sequencing, and a multi-cycle invalidate-all sweep. Sits between the I/O cache controller FSM and backing memory, replacing the fixed 2-way array. The array holds state only; the controller drives lookup, write-back and fill through the same `enable`/`cmp`/`write` protocol.

---
 rtl/cache_pkg.sv | 52 +++++
 rtl/plru_tree.sv | 34 +++
 rtl/cache_nway.sv | 182 ++++++++++++++++++
 tb/tb_cache_nway.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants, state encoding and tree pseudo-LRU helpers for cache_nway.
package cache_pkg;

  localparam int WORD_WIDTH    = 32;
  localparam int MAX_WAY_BITS  = 3;
  localparam int MAX_PLRU_BITS = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } cache_state_t;

  // Walk the PLRU tree from the root; a 0 bit steers toward the lower half.
  function automatic logic [MAX_WAY_BITS-1:0] plru_victim(
    input logic [MAX_PLRU_BITS-1:0] bits,
    input int                       way_bits
  );
    int                      node;
    logic [MAX_WAY_BITS-1:0] vic;
    node = 0;
    vic  = '0;
    for (int lvl = 0; lvl < MAX_WAY_BITS; lvl++) begin
      if (lvl < way_bits) begin
        vic  = {vic[MAX_WAY_BITS-2:0], bits[node]};
        node = 2 * node + 1 + int'(bits[node]);
      end
    end
    return vic;
  endfunction

  // Set every node on the path to `way` so that it points away from `way`.
  function automatic logic [MAX_PLRU_BITS-1:0] plru_update(
    input logic [MAX_PLRU_BITS-1:0] bits,
    input logic [MAX_WAY_BITS-1:0]  way,
    input int                       way_bits
  );
    int                       node;
    logic                     dir;
    logic [MAX_PLRU_BITS-1:0] nb;
    node = 0;
    nb   = bits;
    for (int lvl = 0; lvl < MAX_WAY_BITS; lvl++) begin
      if (lvl < way_bits) begin
        dir      = way[way_bits-1-lvl];
        nb[node] = ~dir;
        node     = 2 * node + 1 + int'(dir);
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Per-set replacement logic: victim selection (invalid ways first, then
// tree PLRU) and the next PLRU state after touching one way.
module plru_tree
  import cache_pkg::*;
#(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         i_bits,
  input  logic [WAYS-1:0]         i_valid,
  input  logic [$clog2(WAYS)-1:0] i_touch,
  output logic [$clog2(WAYS)-1:0] o_victim,
  output logic [WAYS-2:0]         o_next_bits
);

  localparam int WAY_BITS = $clog2(WAYS);

  logic [WAY_BITS-1:0] w_plru_victim;

  // Tree evaluation through the package helpers, resized to this WAYS.
  always_comb begin
    w_plru_victim = WAY_BITS'(plru_victim(MAX_PLRU_BITS'(i_bits), WAY_BITS));
    o_next_bits   = (WAYS-1)'(plru_update(MAX_PLRU_BITS'(i_bits),
                                          MAX_WAY_BITS'(i_touch), WAY_BITS));
  end

  // Lowest-index invalid way overrides the PLRU choice.
  always_comb begin
    o_victim = w_plru_victim;
    for (int i = WAYS - 1; i >= 0; i--) begin
      o_victim = i_valid[i] ? o_victim : WAY_BITS'(i);
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative cache array: tag/data/valid/dirty storage, tree
// PLRU replacement, latched victim way and a one-set-per-cycle flush sweep.
module cache_nway
  import cache_pkg::*;
#(
  parameter int OFFSET_WIDTH = 3,
  parameter int INDEX_WIDTH  = 6,
  parameter int WAYS         = 4,
  parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic                                cmp,
  input  logic                                write,
  input  logic [3:0]                          byte_w_en,
  input  logic                                flush_req,
  input  logic                                valid_in,
  input  logic [TAG_WIDTH-1:0]                tag_in,
  input  logic [INDEX_WIDTH-1:0]              index,
  input  logic [OFFSET_WIDTH-1:0]             word_sel,
  input  logic [31:0]                         data_in,
  input  logic [32*(2**OFFSET_WIDTH)-1:0]     data_block_in,
  output logic                                ready,
  output logic                                hit,
  output logic [$clog2(WAYS)-1:0]             hit_way,
  output logic [$clog2(WAYS)-1:0]             victim_way,
  output logic                                dirty,
  output logic                                valid_out,
  output logic [TAG_WIDTH-1:0]                tag_out,
  output logic [31:0]                         data_out,
  output logic [32*(2**OFFSET_WIDTH)-1:0]     data_wb
);

  localparam int WAY_BITS    = $clog2(WAYS);
  localparam int CACHE_DEPTH = 2 ** INDEX_WIDTH;
  localparam int BLOCK_WIDTH = WORD_WIDTH * (2 ** OFFSET_WIDTH);

  cache_state_t            r_state;
  logic [INDEX_WIDTH-1:0]  r_counter;
  logic                    r_ready;
  logic [WAY_BITS-1:0]     r_victim_way;
  logic [WAYS-1:0]         r_valid [CACHE_DEPTH];
  logic [WAYS-1:0]         r_dirty [CACHE_DEPTH];
  logic [WAYS-2:0]         r_plru  [CACHE_DEPTH];
  logic [TAG_WIDTH-1:0]    r_tag   [WAYS][CACHE_DEPTH];
  logic [BLOCK_WIDTH-1:0]  r_data  [WAYS][CACHE_DEPTH];

  logic [WAYS-1:0]         w_match;
  logic                    w_hit;
  logic [WAY_BITS-1:0]     w_hit_way;
  logic [WAY_BITS-1:0]     w_victim;
  logic [WAY_BITS-1:0]     w_touch_way;
  logic [WAY_BITS-1:0]     w_sel_way;
  logic [WAYS-2:0]         w_next_plru;
  logic                    w_access;
  logic                    w_lookup_hit;
  logic                    w_lookup_miss;
  logic                    w_fill;
  logic [BLOCK_WIDTH-1:0]  w_wr_block;
  logic [BLOCK_WIDTH-1:0]  w_sel_block;

  // Tag compare across all ways; the lowest matching way wins.
  always_comb begin
    w_match   = '0;
    w_hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_match[w] = r_valid[index][w] && (r_tag[w][index] == tag_in);
      w_hit_way  = w_match[w] ? WAY_BITS'(w) : w_hit_way;
    end
  end

  assign w_hit         = |w_match;
  assign w_access      = enable && (r_state == ST_IDLE);
  assign w_lookup_hit  = w_access && cmp && w_hit;
  assign w_lookup_miss = w_access && cmp && !w_hit;
  assign w_fill        = w_access && !cmp && write;
  assign w_touch_way   = cmp ? w_hit_way : r_victim_way;
  assign w_sel_way     = cmp ? (w_hit ? w_hit_way : w_victim) : r_victim_way;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .i_bits      (r_plru[index]),
    .i_valid     (r_valid[index]),
    .i_touch     (w_touch_way),
    .o_victim    (w_victim),
    .o_next_bits (w_next_plru)
  );

  // Merge the byte-enabled write word into the hit way's block.
  always_comb begin
    w_wr_block = r_data[w_hit_way][index];
    for (int b = 0; b < 4; b++) begin
      w_wr_block[int'(word_sel) * 32 + b * 8 +: 8] =
        byte_w_en[b] ? data_in[b * 8 +: 8] : w_wr_block[int'(word_sel) * 32 + b * 8 +: 8];
    end
  end

  assign w_sel_block = r_data[w_sel_way][index];
  assign data_wb     = w_sel_block;
  assign data_out    = w_sel_block[int'(word_sel) * 32 +: 32];
  assign tag_out     = r_tag[w_sel_way][index];
  assign dirty       = r_dirty[index][w_sel_way];
  assign valid_out   = r_valid[index][w_sel_way];
  assign hit         = w_hit;
  assign hit_way     = w_hit_way;
  assign victim_way  = r_victim_way;
  assign ready       = r_ready;

  // IDLE/FLUSH controller; the counter walks every set once per sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_counter <= '0;
      r_ready   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush_req) begin
            r_state   <= ST_FLUSH;
            r_counter <= '0;
            r_ready   <= 1'b0;
          end
        end
        ST_FLUSH: begin
          r_counter <= r_counter + 1'b1;
          if (&r_counter) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Latch the replacement candidate on every lookup miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_victim_way <= '0;
    end else if (w_lookup_miss) begin
      r_victim_way <= w_victim;
    end
  end

  // Valid, dirty and PLRU state: cleared by reset or the flush sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < CACHE_DEPTH; d++) begin
        r_valid[d] <= '0;
        r_dirty[d] <= '0;
        r_plru[d]  <= '0;
      end
    end else if (r_state == ST_FLUSH) begin
      r_valid[r_counter] <= '0;
      r_dirty[r_counter] <= '0;
      r_plru[r_counter]  <= '0;
    end else if (w_lookup_hit) begin
      r_plru[index] <= w_next_plru;
      if (write) begin
        r_dirty[index][w_hit_way] <= 1'b1;
      end
    end else if (w_fill) begin
      r_plru[index]                <= w_next_plru;
      r_valid[index][r_victim_way] <= valid_in;
      r_dirty[index][r_victim_way] <= 1'b0;
    end
  end

  // Tag and data storage; contents are only meaningful where valid is set.
  always_ff @(posedge clk) begin
    if (w_lookup_hit && write) begin
      r_data[w_hit_way][index] <= w_wr_block;
    end else if (w_fill) begin
      r_tag[r_victim_way][index]  <= tag_in;
      r_data[r_victim_way][index] <= data_block_in;
    end
  end

endmodule

// File: tb/tb_cache_nway.sv
// Self-checking bench for cache_nway: table of accesses with a queue of
// expected outputs, plus hand-written flush and reset-abort sequences.
module tb_cache_nway;

  localparam int OP_RD   = 1;
  localparam int OP_WR   = 2;
  localparam int OP_WB   = 3;
  localparam int OP_FILL = 4;

  localparam logic [7:0] M_HIT   = 8'h01;
  localparam logic [7:0] M_HW    = 8'h02;
  localparam logic [7:0] M_VIC   = 8'h04;
  localparam logic [7:0] M_DIRTY = 8'h08;
  localparam logic [7:0] M_VALID = 8'h10;
  localparam logic [7:0] M_TAG   = 8'h20;
  localparam logic [7:0] M_DATA  = 8'h40;
  localparam logic [7:0] M_WB0   = 8'h80;

  typedef struct {
    string       name;
    int          op;
    logic [20:0] tag;
    logic [5:0]  idx;
    logic [2:0]  word;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] seed;
    logic [7:0]  mask;
    logic        e_hit;
    logic [1:0]  e_hw;
    logic [1:0]  e_vic;
    logic        e_dirty;
    logic        e_valid;
    logic [20:0] e_tag;
    logic [31:0] e_data;
    logic [31:0] e_wb0;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable, cmp, write, flush_req, valid_in;
  logic [3:0]   byte_w_en;
  logic [20:0]  tag_in;
  logic [5:0]   index;
  logic [2:0]   word_sel;
  logic [31:0]  data_in;
  logic [255:0] data_block_in;
  logic         ready, hit, dirty, valid_out;
  logic [1:0]   hit_way, victim_way;
  logic [20:0]  tag_out;
  logic [31:0]  data_out;
  logic [255:0] data_wb;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  cache_nway dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cmp(cmp), .write(write),
    .byte_w_en(byte_w_en), .flush_req(flush_req), .valid_in(valid_in),
    .tag_in(tag_in), .index(index), .word_sel(word_sel), .data_in(data_in),
    .data_block_in(data_block_in), .ready(ready), .hit(hit), .hit_way(hit_way),
    .victim_way(victim_way), .dirty(dirty), .valid_out(valid_out),
    .tag_out(tag_out), .data_out(data_out), .data_wb(data_wb)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
    end
  endtask

  function automatic vec_t mkv(input string n, input int op, input int idx, input int tag,
                               input int word, input logic [31:0] wd, input logic [3:0] be,
                               input logic [31:0] seed, input logic [7:0] mask,
                               input logic e_hit, input int e_hw, input int e_vic,
                               input logic e_dirty, input logic e_valid, input int e_tag,
                               input logic [31:0] e_data, input logic [31:0] e_wb0);
    vec_t r;
    r.name = n; r.op = op; r.idx = 6'(idx); r.tag = 21'(tag); r.word = 3'(word);
    r.wdata = wd; r.be = be; r.seed = seed; r.mask = mask; r.e_hit = e_hit;
    r.e_hw = 2'(e_hw); r.e_vic = 2'(e_vic); r.e_dirty = e_dirty; r.e_valid = e_valid;
    r.e_tag = 21'(e_tag); r.e_data = e_data; r.e_wb0 = e_wb0;
    return r;
  endfunction

  task automatic drive_idle();
    enable = 1'b0; cmp = 1'b0; write = 1'b0; byte_w_en = 4'h0; valid_in = 1'b0;
    tag_in = '0; index = '0; word_sel = '0; data_in = '0; data_block_in = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    enable    = 1'b1;
    cmp       = (v.op == OP_RD) || (v.op == OP_WR);
    write     = (v.op == OP_WR) || (v.op == OP_FILL);
    tag_in    = v.tag;
    index     = v.idx;
    word_sel  = v.word;
    data_in   = v.wdata;
    byte_w_en = v.be;
    valid_in  = 1'b1;
    for (int i = 0; i < 8; i++) data_block_in[i * 32 +: 32] = v.seed + 32'(i);
  endtask

  task automatic check_front();
    vec_t e;
    if (exp_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty actual=0 expected=1");
      return;
    end
    e = exp_q.pop_front();
    if ((e.mask & M_HIT)   != 8'h00) chk({e.name, ".hit"},     64'(hit),        64'(e.e_hit));
    if ((e.mask & M_HW)    != 8'h00) chk({e.name, ".hit_way"}, 64'(hit_way),    64'(e.e_hw));
    if ((e.mask & M_VIC)   != 8'h00) chk({e.name, ".victim"},  64'(victim_way), 64'(e.e_vic));
    if ((e.mask & M_DIRTY) != 8'h00) chk({e.name, ".dirty"},   64'(dirty),      64'(e.e_dirty));
    if ((e.mask & M_VALID) != 8'h00) chk({e.name, ".valid"},   64'(valid_out),  64'(e.e_valid));
    if ((e.mask & M_TAG)   != 8'h00) chk({e.name, ".tag"},     64'(tag_out),    64'(e.e_tag));
    if ((e.mask & M_DATA)  != 8'h00) chk({e.name, ".data"},    64'(data_out),   64'(e.e_data));
    if ((e.mask & M_WB0)   != 8'h00) chk({e.name, ".wb0"},     64'(data_wb[31:0]), 64'(e.e_wb0));
  endtask

  // One access per cycle: drive after the edge, compare at the falling edge.
  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    drive_vec(v);
    exp_q.push_back(v);
    @(negedge clk);
    check_front();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; flush_req = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    chk("rst.ready",  64'(ready),      64'd1);
    chk("rst.victim", 64'(victim_way), 64'd0);

    // name, op, idx, tag, word, wdata, be, seed, mask, hit, hw, vic, dirty, valid, tag, data, wb0
    tbl.push_back(mkv("rst_miss", OP_RD,   5, 'h10,  0, 0, 0, 0, M_HIT|M_DIRTY|M_VALID|M_VIC, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("fill0",    OP_FILL, 5, 'h10,  0, 0, 0, 32'h11223344, M_VIC|M_VALID, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("hit0",     OP_RD,   5, 'h10,  0, 0, 0, 0, M_HIT|M_HW|M_DATA|M_DIRTY|M_VALID, 1, 0, 0, 0, 1, 0, 32'h11223344, 0));
    tbl.push_back(mkv("wr_be",    OP_WR,   5, 'h10,  0, 32'hAABBCCDD, 4'b0011, 0, M_HIT|M_HW|M_DIRTY, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("merged",   OP_RD,   5, 'h10,  0, 0, 0, 0, M_HIT|M_DATA|M_DIRTY, 1, 0, 0, 1, 0, 0, 32'h1122CCDD, 0));
    tbl.push_back(mkv("wb_rd",    OP_WB,   5, 0,     1, 0, 0, 0, M_VIC|M_DIRTY|M_VALID|M_TAG|M_DATA|M_WB0, 0, 0, 0, 1, 1, 'h10, 32'h11223345, 32'h1122CCDD));
    tbl.push_back(mkv("s2_m0",    OP_RD,   2, 'h100, 0, 0, 0, 0, M_HIT|M_VALID, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("s2_f0",    OP_FILL, 2, 'h100, 0, 0, 0, 32'h10000000, M_VIC, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("s2_m1",    OP_RD,   2, 'h101, 0, 0, 0, 0, M_HIT|M_VALID, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("s2_f1",    OP_FILL, 2, 'h101, 0, 0, 0, 32'h10100000, M_VIC, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("s2_m2",    OP_RD,   2, 'h102, 0, 0, 0, 0, M_HIT, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("s2_f2",    OP_FILL, 2, 'h102, 0, 0, 0, 32'h10200000, M_VIC, 0, 0, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("s2_m3",    OP_RD,   2, 'h103, 0, 0, 0, 0, M_HIT, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("s2_f3",    OP_FILL, 2, 'h103, 0, 0, 0, 32'h10300000, M_VIC, 0, 0, 3, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("plru_v0",  OP_RD,   2, 'h1FF, 0, 0, 0, 0, M_HIT|M_VALID|M_TAG|M_DIRTY, 0, 0, 0, 0, 1, 'h100, 0, 0));
    tbl.push_back(mkv("touch0",   OP_RD,   2, 'h100, 0, 0, 0, 0, M_HIT|M_HW|M_VIC|M_DATA, 1, 0, 0, 0, 0, 0, 32'h10000000, 0));
    tbl.push_back(mkv("plru_v2",  OP_RD,   2, 'h1FE, 0, 0, 0, 0, M_HIT|M_TAG|M_VALID, 0, 0, 0, 0, 1, 'h102, 0, 0));
    tbl.push_back(mkv("wr_w2",    OP_WR,   2, 'h102, 3, 32'hDEADBEEF, 4'b1111, 0, M_HIT|M_HW|M_VIC, 1, 2, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mkv("wb_dirty", OP_WB,   2, 0,     3, 0, 0, 0, M_VIC|M_TAG|M_DIRTY|M_DATA, 0, 0, 2, 1, 0, 'h102, 32'hDEADBEEF, 0));
    tbl.push_back(mkv("fill_dv",  OP_FILL, 2, 'h200, 0, 0, 0, 32'h20000000, M_VIC|M_DIRTY, 0, 0, 2, 1, 0, 0, 0, 0));
    tbl.push_back(mkv("new_hit",  OP_RD,   2, 'h200, 1, 0, 0, 0, M_HIT|M_HW|M_DIRTY|M_DATA, 1, 2, 0, 0, 0, 0, 32'h20000001, 0));
    tbl.push_back(mkv("old_miss", OP_RD,   2, 'h102, 0, 0, 0, 0, M_HIT|M_VIC|M_TAG, 0, 0, 2, 0, 0, 'h101, 0, 0));
    tbl.push_back(mkv("post_vic", OP_WB,   2, 0,     0, 0, 0, 0, M_VIC|M_TAG, 0, 0, 1, 0, 0, 'h101, 0, 0));
    tbl.push_back(mkv("s5_kept",  OP_RD,   5, 'h10,  0, 0, 0, 0, M_HIT|M_HW|M_DATA, 1, 0, 0, 0, 0, 0, 32'h1122CCDD, 0));
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Flush sweep: the access issued with flush_req still completes, then
    // enable and flush_req are ignored for exactly 64 cycles.
    @(posedge clk); #1;
    flush_req = 1'b1;
    drive_vec(mkv("flush_acc", OP_RD, 5, 'h10, 0, 0, 0, 0, M_HIT, 1, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mkv("flush_acc", OP_RD, 5, 'h10, 0, 0, 0, 0, M_HIT, 1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check_front();
    @(posedge clk); #1;
    drive_vec(mkv("ign_fill", OP_FILL, 5, 'h999, 0, 0, 0, 32'h99990000, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (ready) break;
      cnt++;
      if (cnt == 5) flush_req = 1'b0;
    end
    drive_idle();
    flush_req = 1'b0;
    chk("flush_len", 64'(cnt), 64'd64);

    run_vec(mkv("fl_s5",   OP_RD, 5, 'h10,  0, 0, 0, 0, M_HIT|M_VALID, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vec(mkv("fl_ign",  OP_RD, 5, 'h999, 0, 0, 0, 0, M_HIT, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vec(mkv("fl_s2a",  OP_RD, 2, 'h200, 0, 0, 0, 0, M_HIT|M_VALID|M_DIRTY, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vec(mkv("fl_s2b",  OP_RD, 2, 'h101, 0, 0, 0, 0, M_HIT, 0, 0, 0, 0, 0, 0, 0, 0));

    // Populate a set beyond the first ten, latch victim 1, then abort a flush with reset.
    run_vec(mkv("s40_m",   OP_RD,   40, 'h300, 0, 0, 0, 0, M_HIT, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vec(mkv("s40_f",   OP_FILL, 40, 'h300, 0, 0, 0, 32'h30000000, M_VIC, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vec(mkv("s40_h",   OP_RD,   40, 'h300, 0, 0, 0, 0, M_HIT|M_HW, 1, 0, 0, 0, 0, 0, 0, 0));
    run_vec(mkv("s40_m1",  OP_RD,   40, 'h301, 0, 0, 0, 0, M_HIT, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vec(mkv("s40_v1",  OP_WB,   40, 0,     0, 0, 0, 0, M_VIC, 0, 0, 1, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive_idle();
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!ready) cnt++;
      if (cnt == 10) break;
    end
    chk("abort_reached", 64'(cnt), 64'd10);
    drive_vec(mkv("x", OP_RD, 40, 'h300, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #1;
    chk("abort.ready",  64'(ready),      64'd1);
    chk("abort.victim", 64'(victim_way), 64'd0);
    chk("abort.hit",    64'(hit),        64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mkv("rst_s40", OP_RD, 40, 'h300, 0, 0, 0, 0, M_HIT|M_VALID|M_VIC, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst.ready", 64'(ready), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
